// File: rtl/fifo_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_byte_packer
//  Description : Pops DW-bit FIFO entries and packs NB of them into one wide
//                word on a valid/ready stream; flush emits a partial word.
//  Revision    : 1.0
// ============================================================================
module fifo_byte_packer #(
    parameter int DW        = 8,
    parameter int NB        = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_re,
    input  logic             flush,
    output logic [DW*NB-1:0] out_data,
    output logic [3:0]       out_bytes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam logic [3:0] c_NB = 4'(NB);

    logic [3:0]       r_cnt;
    logic             r_rd_pend;
    logic             r_flush_req;
    logic [DW*NB-1:0] r_asm;

    logic             w_out_free;
    logic             w_xfer;
    logic [3:0]       w_base;
    logic [4:0]       w_occ;
    logic [2:0]       w_lane;
    logic [DW*NB-1:0] w_ordered;

    assign w_out_free = !out_valid || out_ready;
    assign w_xfer     = w_out_free &&
                        ((r_cnt == c_NB) || (r_flush_req && !r_rd_pend && (r_cnt != 4'd0)));
    // Lanes freed by a transfer this cycle can be refilled by a pop issued now.
    assign w_base     = w_xfer ? 4'd0 : r_cnt;
    assign w_occ      = {1'b0, w_base} + {4'd0, r_rd_pend};
    assign fifo_re    = !rst && !fifo_empty && !r_flush_req && !clr && (w_occ < {1'b0, c_NB});
    assign busy       = (r_cnt != 4'd0) || r_rd_pend || out_valid || r_flush_req;
    assign w_lane     = r_cnt[2:0];

    generate
        if (MSB_FIRST) begin : g_msb_first
            for (genvar i = 0; i < NB; i++) begin : g_lane
                assign w_ordered[(NB-1-i)*DW +: DW] = r_asm[i*DW +: DW];
            end
        end else begin : g_lsb_first
            assign w_ordered = r_asm;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_rd_pend   <= 1'b0;
            r_flush_req <= 1'b0;
            r_asm       <= '0;
            out_data    <= '0;
            out_bytes   <= 4'd0;
            out_valid   <= 1'b0;
        end else if (clr) begin
            r_cnt       <= 4'd0;
            r_rd_pend   <= 1'b0;
            r_flush_req <= 1'b0;
            r_asm       <= '0;
            out_data    <= '0;
            out_bytes   <= 4'd0;
            out_valid   <= 1'b0;
        end else begin
            r_rd_pend <= fifo_re;
            if (w_xfer) begin
                // An in-flight pop is never pending here, so no entry is dropped.
                r_cnt       <= 4'd0;
                r_asm       <= '0;
                r_flush_req <= 1'b0;
                out_data    <= w_ordered;
                out_bytes   <= r_cnt;
                out_valid   <= 1'b1;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (r_rd_pend) begin
                    for (int i = 0; i < NB; i++) begin
                        if (w_lane == 3'(i)) begin
                            r_asm[i*DW +: DW] <= fifo_dout;
                        end
                    end
                    r_cnt <= r_cnt + 4'd1;
                end
                if (r_flush_req) begin
                    if ((r_cnt == 4'd0) && !r_rd_pend) begin
                        r_flush_req <= 1'b0;
                    end
                end else if (flush) begin
                    r_flush_req <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_byte_packer
//  Description : Self-checking bench with FIFO model and byte-queue scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_fifo_byte_packer;
    localparam int DW = 8;
    localparam int NB = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        clr        = 1'b0;
    logic        flush      = 1'b0;
    logic        out_ready  = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout  = 8'd0;
    logic        fifo_re;
    logic        out_valid;
    logic        busy;
    logic [31:0] out_data;
    logic [3:0]  out_bytes;

    logic        b_empty = 1'b1;
    logic [7:0]  b_dout  = 8'd0;
    logic        b_zero  = 1'b0;
    logic        b_one   = 1'b1;
    logic        b_re;
    logic        b_valid;
    logic        b_busy;
    logic [31:0] b_data;
    logic [3:0]  b_bytes;

    int          checks   = 0;
    int          failures = 0;
    byte unsigned fq[$];
    byte unsigned exp_q[$];
    byte unsigned bq[$];
    logic [31:0] acc_words[$];
    int          acc_bytes[$];
    bit          allow_partial = 1'b0;
    bit          stall_prev    = 1'b0;
    logic [31:0] stall_data    = 32'd0;
    logic [3:0]  stall_bytes   = 4'd0;
    logic [31:0] b_word        = 32'd0;
    int          b_last_bytes  = 0;
    int          b_cnt         = 0;

    fifo_byte_packer #(.DW(DW), .NB(NB), .MSB_FIRST(1'b0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_re(fifo_re), .flush(flush), .out_data(out_data), .out_bytes(out_bytes),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    fifo_byte_packer #(.DW(DW), .NB(NB), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst), .clr(b_zero), .fifo_empty(b_empty), .fifo_dout(b_dout),
        .fifo_re(b_re), .flush(b_zero), .out_data(b_data), .out_bytes(b_bytes),
        .out_valid(b_valid), .out_ready(b_one), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic push(input byte unsigned b);
        fq.push_back(b);
        exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample before the edge, then update the FIFO models after it.
    task automatic tick();
        logic pre_re, pre_bre, pre_clr;
        #1;
        checks++;
        if (fifo_re && fifo_empty) begin
            failures++;
            $display("FAIL re_when_empty: fifo_re=%0b fifo_empty=%0b required fifo_re=0", fifo_re, fifo_empty);
        end
        checks++;
        if (b_re && b_empty) begin
            failures++;
            $display("FAIL msb_re_when_empty: fifo_re=%0b required 0", b_re);
        end
        if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== stall_data || out_bytes !== stall_bytes) begin
                failures++;
                $display("FAIL stall_hold: valid=%0b data=%h bytes=%0d required valid=1 data=%h bytes=%0d",
                         out_valid, out_data, out_bytes, stall_data, stall_bytes);
            end
        end
        if (out_valid && out_ready) begin
            int nb;
            logic [31:0] w;
            nb = int'(out_bytes);
            w  = 32'd0;
            checks++;
            if (nb < 1 || nb > NB || (!allow_partial && nb != NB) || exp_q.size() < nb) begin
                failures++;
                $display("FAIL out_bytes: got %0d required %0d (expected bytes left %0d)",
                         nb, NB, exp_q.size());
            end else begin
                for (int i = 0; i < nb; i++) w[i*8 +: 8] = exp_q.pop_front();
                if (out_data !== w) begin
                    failures++;
                    $display("FAIL scoreboard_word: got %h required %h", out_data, w);
                end
            end
            acc_words.push_back(out_data);
            acc_bytes.push_back(nb);
        end
        if (b_valid) begin
            b_word       = b_data;
            b_last_bytes = int'(b_bytes);
            b_cnt++;
        end
        stall_prev  = out_valid && !out_ready && !clr;
        stall_data  = out_data;
        stall_bytes = out_bytes;
        pre_re  = fifo_re;
        pre_bre = b_re;
        pre_clr = clr;
        @(posedge clk);
        #1;
        if (pre_re && fq.size() > 0) fifo_dout = fq.pop_front();
        if (pre_bre && bq.size() > 0) b_dout = bq.pop_front();
        if (pre_clr) begin
            fq.delete();
            exp_q.delete();
        end
        fifo_empty = (fq.size() == 0);
        b_empty    = (bq.size() == 0);
        @(negedge clk);
    endtask

    task automatic wait_acc(input int n, input int lim);
        int k;
        k = 0;
        while (acc_words.size() < n && k < lim) begin
            tick();
            k++;
        end
        checks++;
        if (acc_words.size() < n) begin
            failures++;
            $display("FAIL wait_output_timeout: got %0d words required %0d", acc_words.size(), n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        fq.push_back(8'h55);
        fifo_empty = 1'b0;
        #1;
        checks++;
        if (fifo_re !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
            out_bytes !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: re=%0b valid=%0b data=%h bytes=%0d busy=%0b required all 0",
                     fifo_re, out_valid, out_data, out_bytes, busy);
        end
        fq.delete();
        fifo_empty = 1'b1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] w0, w1;
        acc_words.delete(); acc_bytes.delete();
        allow_partial = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        wait_acc(2, 60);
        w0 = (acc_words.size() > 0) ? acc_words[0] : 32'hx;
        w1 = (acc_words.size() > 1) ? acc_words[1] : 32'hx;
        checks++;
        if (w0 !== 32'h04030201 || w1 !== 32'h08070605) begin
            failures++;
            $display("FAIL basic_words: got %h %h required 04030201 08070605", w0, w1);
        end
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || acc_words.size() != 2) begin
            failures++;
            $display("FAIL basic_idle: busy=%0b words=%0d required busy=0 words=2", busy, acc_words.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] w1, w2;
        acc_words.delete(); acc_bytes.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        repeat (30) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201 || fifo_re !== 1'b0 || fq.size() != 4) begin
            failures++;
            $display("FAIL stall_state: valid=%0b data=%h re=%0b fifo_left=%0d required 1 04030201 0 4",
                     out_valid, out_data, fifo_re, fq.size());
        end
        out_ready = 1'b1;
        wait_acc(3, 60);
        w1 = (acc_words.size() > 1) ? acc_words[1] : 32'hx;
        w2 = (acc_words.size() > 2) ? acc_words[2] : 32'hx;
        checks++;
        if (w1 !== 32'h08070605 || w2 !== 32'h0C0B0A09) begin
            failures++;
            $display("FAIL stall_release: got %h %h required 08070605 0C0B0A09", w1, w2);
        end
        repeat (3) tick();
    endtask

    task automatic test_flush();
        logic [31:0] w0;
        int          n0;
        acc_words.delete(); acc_bytes.delete();
        allow_partial = 1'b1;
        out_ready = 1'b1;
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (10) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL partial_hold: valid=%0b busy=%0b required valid=0 busy=1", out_valid, busy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_acc(1, 20);
        w0 = (acc_words.size() > 0) ? acc_words[0] : 32'hx;
        n0 = (acc_bytes.size() > 0) ? acc_bytes[0] : -1;
        checks++;
        if (w0 !== 32'h00CCBBAA || n0 != 3) begin
            failures++;
            $display("FAIL flush_word: got %h/%0d required 00CCBBAA/3", w0, n0);
        end
        repeat (3) tick();
        acc_words.delete(); acc_bytes.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL empty_flush_pending: busy=%0b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_flush_clear: busy=%0b required 0", busy);
        end
        repeat (5) tick();
        checks++;
        if (acc_words.size() != 0) begin
            failures++;
            $display("FAIL empty_flush_output: words=%0d required 0", acc_words.size());
        end
    endtask

    task automatic test_flush_inflight();
        int n0;
        acc_words.delete(); acc_bytes.delete();
        out_ready = 1'b1;
        push(8'h31); push(8'h32);
        repeat (6) tick();
        push(8'h33);
        flush = 1'b1;
        #1;
        checks++;
        if (fifo_re !== 1'b1) begin
            failures++;
            $display("FAIL inflight_pop: fifo_re=%0b required 1", fifo_re);
        end
        tick();
        flush = 1'b0;
        wait_acc(1, 20);
        n0 = (acc_bytes.size() > 0) ? acc_bytes[0] : -1;
        checks++;
        if (n0 != 3) begin
            failures++;
            $display("FAIL inflight_bytes: got %0d required 3", n0);
        end
        repeat (3) tick();
    endtask

    task automatic test_clr();
        logic [31:0] w0;
        acc_words.delete(); acc_bytes.delete();
        allow_partial = 1'b0;
        out_ready = 1'b0;
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || acc_words.size() != 0) begin
            failures++;
            $display("FAIL clr_state: busy=%0b words=%0d required 0 0", busy, acc_words.size());
        end
        for (int i = 1; i <= 4; i++) push(8'(i));
        wait_acc(1, 30);
        repeat (10) tick();
        w0 = (acc_words.size() > 0) ? acc_words[0] : 32'hx;
        checks++;
        if (acc_words.size() != 1 || w0 !== 32'h04030201) begin
            failures++;
            $display("FAIL clr_after: words=%0d first=%h required 1 04030201", acc_words.size(), w0);
        end
    endtask

    task automatic test_async_rst();
        int k;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'($urandom_range(0, 255)));
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup: out_valid=%0b required 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_bytes !== 4'd0 ||
            busy !== 1'b0 || fifo_re !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: valid=%0b data=%h bytes=%0d busy=%0b re=%0b required all 0",
                     out_valid, out_data, out_bytes, busy, fifo_re);
        end
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        int k;
        bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33); bq.push_back(8'h44);
        b_empty = 1'b0;
        k = 0;
        while (b_cnt < 1 && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (b_word !== 32'h11223344 || b_last_bytes != 4) begin
            failures++;
            $display("FAIL msb_first_word: got %h/%0d required 11223344/4", b_word, b_last_bytes);
        end
        repeat (3) tick();
        checks++;
        if (b_busy !== 1'b0 || b_cnt != 1) begin
            failures++;
            $display("FAIL msb_first_idle: busy=%0b words=%0d required 0 1", b_busy, b_cnt);
        end
    endtask

    task automatic test_random();
        int pushed, k;
        acc_words.delete(); acc_bytes.delete();
        allow_partial = 1'b0;
        pushed = 0;
        k = 0;
        while ((pushed < 48 || exp_q.size() > 0) && k < 3000) begin
            if (pushed < 48 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom_range(0, 255)));
                pushed++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || acc_words.size() != 12) begin
            failures++;
            $display("FAIL random_drain: left=%0d words=%0d required 0 12", exp_q.size(), acc_words.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_flush_inflight();
        test_clr();
        test_async_rst();
        test_msb_first();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
